rtc_calendar: RTL and testbench
===============================

# rtc_calendar

Parametrised second-to-year calendar counter for the Millennium Clock datapath. It replaces the fixed sec/min/hour/day/month/year chain with a single block that adds:
- a configurable year range with wrap signalling
- full Gregorian leap-year rules
- day clamping on month/year edits
- a 12/24-hour display mode
- an optional day-of-week counter

It sits between the 1 Hz tick source and the BCD conversion / display stage.

## Interface
Parameters:
- YEAR_BASE, 2000, lowest representable year
- YEAR_SPAN, 1000, number of representable years; top year = YEAR_BASE+YEAR_SPAN-1
- YEAR_W, 12, width of year_bin; must hold YEAR_BASE+YEAR_SPAN-1
- RESET_YEAR, 2000, year loaded on reset; must be within range
- RESET_DOW, 6, day of week loaded on reset (0=Sunday; 2000-01-01 is Saturday)

Ports:
- clk_1Hz  in  1  counting clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en_1  in  1  count enable; advances time by one second per edge when high
- up  in  1  increment selected field (level sampled each edge)
- down  in  1  decrement selected field
- select_item  in  3  0=run, 1=sec, 2=min, 3=hour, 4=day, 5=month, 6=year, 7=run
- mode_12h  in  1  1 = 12-hour display on hour_disp/pm
- sec_bin  out  6  seconds 0-59
- min_bin  out  6  minutes 0-59
- hour_bin  out  5  hours 0-23 (always 24-hour)
- hour_disp  out  5  display hour: 0-23, or 1-12 when mode_12h
- pm  out  1  1 when hour_bin>=12 and mode_12h; else 0
- day_bin  out  5  day of month 1-31
- month_bin  out  4  month 1-12
- year_bin  out  YEAR_W  absolute year
- leap_year  out  1  current year is leap
- year_wrap  out  1  one-cycle pulse when year wraps top→YEAR_BASE
- dow  out  3  day of week 0-6 (only with RTC_DOW_EN)

## Operation
- Reset values:
  - sec/min/hour = 0; day = 1; month = 1; year = RESET_YEAR
  - dow = RESET_DOW; year_wrap = 0
  - hour_disp = 12 if mode_12h, else 0; pm = 0
- Run mode (select_item 0 or 7):
  - If en_1: sec increments; carries ripple sec→min→hour→day→month→year in the same edge.
  - Day limits: 31; 30 for months 4/6/9/11; February 29 if leap, else 28.
  - Leap rule: divisible by 4 and (not by 100 or by 400).
  - Year wrap: at the top year, year → YEAR_BASE and year_wrap pulses for one cycle.
  - up/down are ignored in run mode.
- Set mode (select_item 1-6):
  - Counting is frozen regardless of en_1.
  - up alone: the selected field +1, wrapping within its range (sec 59→0, day max→1, month 12→1, year top→YEAR_BASE). No carry to other fields; year_wrap stays 0.
  - down alone: the selected field -1, wrapping the other way (sec 0→59, day 1→max, month 1→12, year YEAR_BASE→top).
  - up and down together: no change.
- Day clamp: whenever month or year changes (by counting or by adjust) and day_bin exceeds the new month's maximum, day_bin is set to that maximum on the same edge. Example: 31-Mar, month down → 29-Feb (leap) or 28-Feb.
- dow:
  - Increments modulo 7 on every run-mode day carry.
  - Day adjust ±1 moves dow ±1 modulo 7. Month/year adjust and day clamp leave dow unchanged.
- hour_disp mapping in 12-hour mode: 0→12, 1-12→same, 13-23→minus 12.
- Outputs are combinational from registered state: hour_disp, pm, leap_year.

## Timing
- Single clock domain (clk_1Hz); every register updates on the rising edge.
- Latency:
  - Run-mode state changes appear one edge after en_1 is sampled high.
  - Adjusts appear one edge after up/down are sampled.
- The full carry chain resolves within one edge. 23:59:59 31-Dec top-year becomes 00:00:00 01-Jan YEAR_BASE in one edge, with year_wrap=1 for that cycle only.
- rst has priority over en_1, up, down, and select_item on the same edge.
- Changing select_item mid-operation takes effect on the next edge; no state is lost.
- mode_12h affects only hour_disp/pm, combinationally, with no state change.
- up/down are level-sampled. Upstream debounce/one-shot logic delivers one-cycle pulses; holding a level adjusts once per edge.

## Configuration
- RTC_DOW_EN defined:
  - dow register and output are present; behaviour as above.
- RTC_DOW_EN undefined:
  - No dow port and no dow register.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst for 1 edge → 00:00:00, 01-01-2000, dow=6, leap_year=1, year_wrap=0.
- Leap carry: load 23:59:59 28-02-2100 via set mode, en_1 one edge → 00:00:00 01-03-2100. Then 28-02-2000 → 29-02-2000. Then 29-02-2000 rollover → 01-03-2000.
- Year wrap: 23:59:59 31-12-2999, en_1 one edge → 00:00:00 01-01-2000, year_wrap high exactly one cycle. With RTC_DOW_EN, dow advances by 1.
- Set mode:
  - select_item=1, sec=59, up → sec=0, min unchanged.
  - select_item=6, year=2000, down → year=2999.
  - up and down together → no change.
  - en_1 high during set mode → no counting.
- Clamp: 31-03-2001, select_item=5, down → 28-02-2001. Then select_item=6 with 29-02-2004, up → 28-02-2005.
- 12h mode: hour_bin 0/12/13 with mode_12h=1 → hour_disp/pm = 12/0, 12/1, 1/1. With mode_12h=0 → 0/0, 12/0, 13/0.

Source files
------------

// File: rtl/rtc_calendar.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rtc_calendar
//  Brief    : Second-to-year calendar counter with Gregorian leap years,
//             configurable year range with wrap pulse, day clamping on
//             month/year edits, 12/24-hour display mapping and an optional
//             day-of-week counter (enabled by defining RTC_DOW_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_calendar #(
    parameter int YEAR_BASE  = 2000,
    parameter int YEAR_SPAN  = 1000,
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2000,
    parameter int RESET_DOW  = 6
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              en_1,
    input  logic              up,
    input  logic              down,
    input  logic [2:0]        select_item,
    input  logic              mode_12h,
    output logic [5:0]        sec_bin,
    output logic [5:0]        min_bin,
    output logic [4:0]        hour_bin,
    output logic [4:0]        hour_disp,
    output logic              pm,
    output logic [4:0]        day_bin,
    output logic [3:0]        month_bin,
    output logic [YEAR_W-1:0] year_bin,
    output logic              leap_year,
`ifdef RTC_DOW_EN
    output logic [2:0]        dow,
`endif
    output logic              year_wrap
);

    localparam logic [YEAR_W-1:0] c_year_base  = YEAR_W'(YEAR_BASE);
    localparam logic [YEAR_W-1:0] c_year_top   = YEAR_W'(YEAR_BASE + YEAR_SPAN - 1);
    localparam logic [YEAR_W-1:0] c_reset_year = YEAR_W'(RESET_YEAR);

    localparam logic [2:0] c_sel_sec   = 3'd1;
    localparam logic [2:0] c_sel_min   = 3'd2;
    localparam logic [2:0] c_sel_hour  = 3'd3;
    localparam logic [2:0] c_sel_day   = 3'd4;
    localparam logic [2:0] c_sel_month = 3'd5;
    localparam logic [2:0] c_sel_year  = 3'd6;

    // Elaboration-time sanity checks on the configuration
    if ((RESET_YEAR < YEAR_BASE) || (RESET_YEAR > YEAR_BASE + YEAR_SPAN - 1)) begin : g_chk_reset_year
        $error("rtc_calendar: RESET_YEAR outside the representable range");
    end
    if ((RESET_DOW < 0) || (RESET_DOW > 6)) begin : g_chk_reset_dow
        $error("rtc_calendar: RESET_DOW must be 0..6");
    end
    if ((YEAR_BASE + YEAR_SPAN - 1) >= (2 ** YEAR_W)) begin : g_chk_year_w
        $error("rtc_calendar: YEAR_W too narrow for the top year");
    end

    // Gregorian rule: divisible by 4 and (not by 100, or by 400)
    function automatic logic f_is_leap(input logic [YEAR_W-1:0] year);
        logic [31:0] y;
        y = 32'(year);
        return ((y % 32'd4) == 32'd0) &&
               (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
    endfunction

    function automatic logic [4:0] f_days_in_month(input logic [3:0] month, input logic leap);
        case (month)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    logic [5:0]        r_sec,   w_sec_nxt;
    logic [5:0]        r_min,   w_min_nxt;
    logic [4:0]        r_hour,  w_hour_nxt;
    logic [4:0]        r_day,   w_day_nxt;
    logic [3:0]        r_month, w_month_nxt;
    logic [YEAR_W-1:0] r_year,  w_year_nxt;
    logic              r_year_wrap, w_year_wrap_nxt;
`ifdef RTC_DOW_EN
    logic [2:0]        r_dow,   w_dow_nxt;
`endif

    logic              w_run;
    logic              w_adj;
    logic              w_leap;
    logic [4:0]        w_dmax;
    logic              w_sec_c, w_min_c, w_hour_c, w_day_c, w_mon_c, w_year_c;
    logic [3:0]        w_month_adj;
    logic [YEAR_W-1:0] w_year_adj;
    logic [4:0]        w_dmax_month_adj;
    logic [4:0]        w_dmax_year_adj;

    assign w_run  = (select_item == 3'd0) || (select_item == 3'd7);
    // Exactly one of up/down asserted requests an adjust; both cancel out
    assign w_adj  = up ^ down;
    assign w_leap = f_is_leap(r_year);
    assign w_dmax = f_days_in_month(r_month, w_leap);

    // Ripple carry terms: each stage carries only when all lower stages wrap
    assign w_sec_c  = (r_sec == 6'd59);
    assign w_min_c  = w_sec_c && (r_min == 6'd59);
    assign w_hour_c = w_min_c && (r_hour == 5'd23);
    assign w_day_c  = w_hour_c && (r_day == w_dmax);
    assign w_mon_c  = w_day_c && (r_month == 4'd12);
    assign w_year_c = w_mon_c && (r_year == c_year_top);

    // Candidate month/year after an adjust, and the day limit they imply
    assign w_month_adj = up ? ((r_month == 4'd12) ? 4'd1 : r_month + 4'd1)
                            : ((r_month == 4'd1) ? 4'd12 : r_month - 4'd1);
    assign w_year_adj  = up ? ((r_year == c_year_top) ? c_year_base : r_year + 1'b1)
                            : ((r_year == c_year_base) ? c_year_top : r_year - 1'b1);
    assign w_dmax_month_adj = f_days_in_month(w_month_adj, w_leap);
    assign w_dmax_year_adj  = f_days_in_month(r_month, f_is_leap(w_year_adj));

    // Next-state: run-mode counting with full carry chain, or single-field adjust
    always_comb begin
        w_sec_nxt       = r_sec;
        w_min_nxt       = r_min;
        w_hour_nxt      = r_hour;
        w_day_nxt       = r_day;
        w_month_nxt     = r_month;
        w_year_nxt      = r_year;
        w_year_wrap_nxt = 1'b0;
`ifdef RTC_DOW_EN
        w_dow_nxt       = r_dow;
`endif
        if (w_run) begin
            if (en_1) begin
                w_sec_nxt = w_sec_c ? 6'd0 : r_sec + 6'd1;
                if (w_sec_c) begin
                    w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                end
                if (w_min_c) begin
                    w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                end
                // A carry out of the hour field starts a new day
                if (w_hour_c) begin
                    w_day_nxt = (r_day == w_dmax) ? 5'd1 : r_day + 5'd1;
`ifdef RTC_DOW_EN
                    w_dow_nxt = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
`endif
                end
                // Day restarts at 1 on month/year carry, so no clamp is needed here
                if (w_day_c) begin
                    w_month_nxt = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                end
                if (w_mon_c) begin
                    w_year_nxt      = w_year_c ? c_year_base : r_year + 1'b1;
                    w_year_wrap_nxt = w_year_c;
                end
            end
        end else if (w_adj) begin
            case (select_item)
                c_sel_sec: begin
                    w_sec_nxt = up ? ((r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1)
                                   : ((r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1);
                end
                c_sel_min: begin
                    w_min_nxt = up ? ((r_min == 6'd59) ? 6'd0 : r_min + 6'd1)
                                   : ((r_min == 6'd0) ? 6'd59 : r_min - 6'd1);
                end
                c_sel_hour: begin
                    w_hour_nxt = up ? ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1)
                                    : ((r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1);
                end
                c_sel_day: begin
                    w_day_nxt = up ? ((r_day >= w_dmax) ? 5'd1 : r_day + 5'd1)
                                   : ((r_day <= 5'd1) ? w_dmax : r_day - 5'd1);
`ifdef RTC_DOW_EN
                    w_dow_nxt = up ? ((r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1)
                                   : ((r_dow == 3'd0) ? 3'd6 : r_dow - 3'd1);
`endif
                end
                c_sel_month: begin
                    w_month_nxt = w_month_adj;
                    if (r_day > w_dmax_month_adj) begin
                        w_day_nxt = w_dmax_month_adj;
                    end
                end
                c_sel_year: begin
                    w_year_nxt = w_year_adj;
                    if (r_day > w_dmax_year_adj) begin
                        w_day_nxt = w_dmax_year_adj;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hour      <= 5'd0;
            r_day       <= 5'd1;
            r_month     <= 4'd1;
            r_year      <= c_reset_year;
            r_year_wrap <= 1'b0;
`ifdef RTC_DOW_EN
            r_dow       <= 3'(RESET_DOW);
`endif
        end else begin
            r_sec       <= w_sec_nxt;
            r_min       <= w_min_nxt;
            r_hour      <= w_hour_nxt;
            r_day       <= w_day_nxt;
            r_month     <= w_month_nxt;
            r_year      <= w_year_nxt;
            r_year_wrap <= w_year_wrap_nxt;
`ifdef RTC_DOW_EN
            r_dow       <= w_dow_nxt;
`endif
        end
    end

    // Display hour: 0 shows as 12, 13-23 fold down by 12 in 12-hour mode
    always_comb begin
        hour_disp = r_hour;
        pm        = 1'b0;
        if (mode_12h) begin
            pm = (r_hour >= 5'd12);
            if (r_hour == 5'd0) begin
                hour_disp = 5'd12;
            end else if (r_hour > 5'd12) begin
                hour_disp = r_hour - 5'd12;
            end
        end
    end

    assign sec_bin   = r_sec;
    assign min_bin   = r_min;
    assign hour_bin  = r_hour;
    assign day_bin   = r_day;
    assign month_bin = r_month;
    assign year_bin  = r_year;
    assign leap_year = w_leap;
    assign year_wrap = r_year_wrap;
`ifdef RTC_DOW_EN
    assign dow       = r_dow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rtc_calendar
//  Brief    : Self-checking bench for rtc_calendar: vector table, directed
//             calendar corner sequences and randomized traffic against a
//             behavioural calendar model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_calendar;

    localparam int c_yb = 2000;
    localparam int c_ys = 1000;
    localparam int c_yt = c_yb + c_ys - 1;

    logic        clk_1Hz = 1'b0;
    logic        rst = 1'b1, en_1 = 1'b0, up = 1'b0, down = 1'b0, mode_12h = 1'b0;
    logic [2:0]  select_item = 3'd0;
    logic [5:0]  sec_bin, min_bin;
    logic [4:0]  hour_bin, hour_disp, day_bin;
    logic [3:0]  month_bin;
    logic [11:0] year_bin;
    logic        pm, leap_year, year_wrap;
`ifdef RTC_DOW_EN
    logic [2:0]  dow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time of day as seconds since midnight, date as plain ints
    int m_tod, m_day, m_mon, m_yr, m_dow, m_wrap;

    always #5 clk_1Hz = ~clk_1Hz;

    rtc_calendar dut (
`ifdef RTC_DOW_EN
        .dow         (dow),
`endif
        .clk_1Hz     (clk_1Hz),
        .rst         (rst),
        .en_1        (en_1),
        .up          (up),
        .down        (down),
        .select_item (select_item),
        .mode_12h    (mode_12h),
        .sec_bin     (sec_bin),
        .min_bin     (min_bin),
        .hour_bin    (hour_bin),
        .hour_disp   (hour_disp),
        .pm          (pm),
        .day_bin     (day_bin),
        .month_bin   (month_bin),
        .year_bin    (year_bin),
        .leap_year   (leap_year),
        .year_wrap   (year_wrap)
    );

    function automatic int is_leap(input int y);
        return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
    endfunction

    function automatic int dim(input int mo, input int y);
        int days [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && is_leap(y) == 1) return 29;
        return days[mo-1];
    endfunction

    task automatic model_new_day();
        m_dow = (m_dow + 1) % 7;
        if (m_day < dim(m_mon, m_yr)) m_day++;
        else begin
            m_day = 1;
            if (m_mon < 12) m_mon++;
            else begin
                m_mon = 1;
                if (m_yr < c_yt) m_yr++;
                else begin
                    m_yr   = c_yb;
                    m_wrap = 1;
                end
            end
        end
    endtask

    task automatic model_step(input int r, input int e, input int sel, input int u, input int d);
        int dl, hh, mm, ss;
        if (r != 0) begin
            m_tod = 0; m_day = 1; m_mon = 1; m_yr = 2000; m_dow = 6; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (sel == 0 || sel == 7) begin
            if (e != 0) begin
                m_tod = (m_tod + 1) % 86400;
                if (m_tod == 0) model_new_day();
            end
        end else if ((u != 0) != (d != 0)) begin
            dl = (u != 0) ? 1 : -1;
            hh = m_tod / 3600;
            mm = (m_tod / 60) % 60;
            ss = m_tod % 60;
            case (sel)
                1: ss = (ss + dl + 60) % 60;
                2: mm = (mm + dl + 60) % 60;
                3: hh = (hh + dl + 24) % 24;
                4: begin
                    m_day = ((m_day - 1 + dl + dim(m_mon, m_yr)) % dim(m_mon, m_yr)) + 1;
                    m_dow = (m_dow + dl + 7) % 7;
                end
                5: m_mon = ((m_mon - 1 + dl + 12) % 12) + 1;
                default: m_yr = c_yb + ((m_yr - c_yb + dl + c_ys) % c_ys);
            endcase
            if (m_day > dim(m_mon, m_yr)) m_day = dim(m_mon, m_yr);
            m_tod = hh * 3600 + mm * 60 + ss;
        end
    endtask

    // Apply one edge worth of inputs to both DUT and model, then settle past the edge
    task automatic drive(input int r, input int e, input int sel, input int u, input int d);
        rst         = (r != 0);
        en_1        = (e != 0);
        select_item = 3'(sel);
        up          = (u != 0);
        down        = (d != 0);
        model_step(r, e, sel, u, d);
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int h;
        h = m_tod / 3600;
        chk({tag, ".sec"},   int'(sec_bin),   m_tod % 60);
        chk({tag, ".min"},   int'(min_bin),   (m_tod / 60) % 60);
        chk({tag, ".hour"},  int'(hour_bin),  h);
        chk({tag, ".day"},   int'(day_bin),   m_day);
        chk({tag, ".month"}, int'(month_bin), m_mon);
        chk({tag, ".year"},  int'(year_bin),  m_yr);
        chk({tag, ".leap"},  int'(leap_year), is_leap(m_yr));
        chk({tag, ".wrap"},  int'(year_wrap), m_wrap);
        chk({tag, ".hdisp"}, int'(hour_disp), mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h);
        chk({tag, ".pm"},    int'(pm),        (mode_12h && h >= 12) ? 1 : 0);
`ifdef RTC_DOW_EN
        chk({tag, ".dow"},   int'(dow),       m_dow);
`endif
    endtask

    task automatic chk_date(input string tag, input int h, input int mi, input int s,
                            input int d, input int mo, input int y);
        chk({tag, ".sec"},   int'(sec_bin),   s);
        chk({tag, ".min"},   int'(min_bin),   mi);
        chk({tag, ".hour"},  int'(hour_bin),  h);
        chk({tag, ".day"},   int'(day_bin),   d);
        chk({tag, ".month"}, int'(month_bin), mo);
        chk({tag, ".year"},  int'(year_bin),  y);
    endtask

    // Walk every field to its target through set mode (year first so clamps settle)
    task automatic load(input int h, input int mi, input int s, input int d, input int mo, input int y);
        for (int k = 0; k < 1100 && m_yr != y; k++)  drive(0, 0, 6, 1, 0);
        for (int k = 0; k < 12 && m_mon != mo; k++)  drive(0, 0, 5, 1, 0);
        for (int k = 0; k < 31 && m_day != d; k++)   drive(0, 0, 4, 1, 0);
        for (int k = 0; k < 24 && m_tod / 3600 != h; k++)         drive(0, 0, 3, 1, 0);
        for (int k = 0; k < 60 && (m_tod / 60) % 60 != mi; k++)   drive(0, 0, 2, 1, 0);
        for (int k = 0; k < 60 && m_tod % 60 != s; k++)           drive(0, 0, 1, 1, 0);
        check_model("load");
    endtask

    typedef struct {
        int rst; int en; int sel; int up; int dn; int m12;
        int sec; int mn; int hr; int day; int mon; int yr; int hd; int pm;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dow_before;
        int r, e, sel, u, d;

        //            rst en sel up dn m12  sec min hr day mon  yr    hd pm
        tbl[0]  = '{1, 0, 0, 0, 0, 1,   0,  0,  0,  1, 1, 2000, 12, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 1,   1,  0,  0,  1, 1, 2000, 12, 0};
        tbl[2]  = '{0, 0, 1, 0, 1, 1,   0,  0,  0,  1, 1, 2000, 12, 0};
        tbl[3]  = '{0, 0, 1, 0, 1, 1,  59,  0,  0,  1, 1, 2000, 12, 0};
        tbl[4]  = '{0, 0, 1, 1, 0, 1,   0,  0,  0,  1, 1, 2000, 12, 0};
        tbl[5]  = '{0, 1, 1, 1, 1, 1,   0,  0,  0,  1, 1, 2000, 12, 0};
        tbl[6]  = '{0, 1, 3, 1, 0, 1,   0,  0,  1,  1, 1, 2000,  1, 0};
        tbl[7]  = '{0, 0, 3, 0, 1, 0,   0,  0,  0,  1, 1, 2000,  0, 0};
        tbl[8]  = '{0, 0, 3, 0, 1, 1,   0,  0, 23,  1, 1, 2000, 11, 1};
        tbl[9]  = '{0, 1, 0, 1, 0, 1,   1,  0, 23,  1, 1, 2000, 11, 1};
        tbl[10] = '{0, 0, 6, 0, 1, 0,   1,  0, 23,  1, 1, 2999, 23, 0};
        tbl[11] = '{0, 0, 6, 1, 0, 0,   1,  0, 23,  1, 1, 2000, 23, 0};
        tbl[12] = '{0, 0, 4, 0, 1, 0,   1,  0, 23, 31, 1, 2000, 23, 0};
        tbl[13] = '{0, 0, 5, 1, 0, 0,   1,  0, 23, 29, 2, 2000, 23, 0};
        tbl[14] = '{0, 0, 6, 1, 0, 0,   1,  0, 23, 28, 2, 2001, 23, 0};
        tbl[15] = '{0, 0, 7, 1, 0, 0,   1,  0, 23, 28, 2, 2001, 23, 0};
        tbl[16] = '{0, 0, 2, 1, 0, 1,   1,  1, 23, 28, 2, 2001, 11, 1};
        tbl[17] = '{0, 0, 3, 1, 0, 1,   1,  1,  0, 28, 2, 2001, 12, 0};

        // Vector table
        for (int i = 0; i < 18; i++) begin
            mode_12h = (tbl[i].m12 != 0);
            drive(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].up, tbl[i].dn);
            chk_date($sformatf("vec%0d", i), tbl[i].hr, tbl[i].mn, tbl[i].sec,
                     tbl[i].day, tbl[i].mon, tbl[i].yr);
            chk($sformatf("vec%0d.hdisp", i), int'(hour_disp), tbl[i].hd);
            chk($sformatf("vec%0d.pm", i),    int'(pm),        tbl[i].pm);
        end
        check_model("vec_end");

        // Reset state
        mode_12h = 1'b0;
        drive(1, 1, 1, 1, 0);
        chk_date("reset", 0, 0, 0, 1, 1, 2000);
        chk("reset.leap", int'(leap_year), 1);
        chk("reset.wrap", int'(year_wrap), 0);
`ifdef RTC_DOW_EN
        chk("reset.dow", int'(dow), 6);
`endif

        // Leap carries: 2100 is not leap, 2000 is
        load(23, 59, 59, 28, 2, 2100);
        drive(0, 1, 0, 0, 0);
        chk_date("feb2100", 0, 0, 0, 1, 3, 2100);
        chk("feb2100.leap", int'(leap_year), 0);
        load(23, 59, 59, 28, 2, 2000);
        drive(0, 1, 0, 0, 0);
        chk_date("feb28_2000", 0, 0, 0, 29, 2, 2000);
        load(23, 59, 59, 29, 2, 2000);
        drive(0, 1, 0, 0, 0);
        chk_date("feb29_2000", 0, 0, 0, 1, 3, 2000);

        // Year wrap from the top year
        load(23, 59, 59, 31, 12, 2999);
        dow_before = m_dow;
        drive(0, 1, 7, 0, 0);
        chk_date("wrap", 0, 0, 0, 1, 1, 2000);
        chk("wrap.pulse", int'(year_wrap), 1);
`ifdef RTC_DOW_EN
        chk("wrap.dow", int'(dow), (dow_before + 1) % 7);
`endif
        drive(0, 0, 0, 0, 0);
        chk("wrap.pulse_end", int'(year_wrap), 0);

        // Set mode freezes counting; year adjust wraps without a pulse
        drive(0, 1, 2, 0, 0);
        chk_date("freeze", 0, 0, 0, 1, 1, 2000);
        drive(0, 1, 6, 0, 1);
        chk_date("yr_down", 0, 0, 0, 1, 1, 2999);
        chk("yr_down.wrap", int'(year_wrap), 0);
        drive(0, 0, 6, 1, 0);
        chk_date("yr_up", 0, 0, 0, 1, 1, 2000);
        chk("yr_up.wrap", int'(year_wrap), 0);

        // Day clamp on month and year edits
        load(0, 0, 0, 31, 3, 2001);
        drive(0, 0, 5, 0, 1);
        chk_date("clamp_mon", 0, 0, 0, 28, 2, 2001);
        load(0, 0, 0, 29, 2, 2004);
        drive(0, 0, 6, 1, 0);
        chk_date("clamp_yr", 0, 0, 0, 28, 2, 2005);
        check_model("clamp_yr");

        // 12-hour mapping is purely combinational
        load(12, 0, 0, 28, 2, 2005);
        mode_12h = 1'b1; #1;
        chk("h12.m12.hdisp", int'(hour_disp), 12); chk("h12.m12.pm", int'(pm), 1);
        mode_12h = 1'b0; #1;
        chk("h12.m24.hdisp", int'(hour_disp), 12); chk("h12.m24.pm", int'(pm), 0);
        drive(0, 0, 3, 1, 0);
        chk("h13.m24.hdisp", int'(hour_disp), 13); chk("h13.m24.pm", int'(pm), 0);
        mode_12h = 1'b1; #1;
        chk("h13.m12.hdisp", int'(hour_disp), 1);  chk("h13.m12.pm", int'(pm), 1);
        load(0, 0, 0, 28, 2, 2005);
        chk("h0.m12.hdisp", int'(hour_disp), 12);  chk("h0.m12.pm", int'(pm), 0);
        mode_12h = 1'b0; #1;
        chk("h0.m24.hdisp", int'(hour_disp), 0);   chk("h0.m24.pm", int'(pm), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 499) == 0) ? 1 : 0;
            sel = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7));
            e   = ($urandom_range(0, 9) != 0) ? 1 : 0;
            u   = int'($urandom_range(0, 1));
            d   = int'($urandom_range(0, 1));
            mode_12h = ($urandom_range(0, 1) == 1);
            drive(r, e, sel, u, d);
            check_model("rnd");
        end

        drive(1, 0, 0, 0, 0);
        check_model("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
